// File: rtl/result_capture_mem.sv
// result_capture_mem: captures N result words over valid/ready, then streams them back out in order.
// Optional build macro RESULT_CAPTURE_NAN_CHECK_EN enables the sticky non-finite (NaN/Inf) flag.
module result_capture_mem #(
   parameter int N     = 4,
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   in_valid,
   input  logic [WIDTH-1:0]       in_data,
   output logic                   in_ready,
   input  logic                   rd_en,
   output logic                   out_valid,
   output logic [WIDTH-1:0]       out_data,
   input  logic                   out_ready,
   output logic                   full,
   output logic [$clog2(N+1)-1:0] count,
   output logic                   nan_flag
);
   localparam int CW = $clog2(N+1);
   localparam int AW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_FULL, S_DRAIN} state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] mem [0:N-1];
   logic [CW-1:0]    wr_ptr, rd_ptr;
   logic             restart, accept, xfer, load, done;

   assign in_ready = (state == S_CAPTURE);
   assign full     = (state == S_FULL) || (state == S_DRAIN);

   // state register; reset aborts any run in progress
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;

   // next state and handshake qualifiers; start beats a same-cycle word and is ignored while draining
   always_comb begin
      state_n = state;
      restart = start && (state != S_DRAIN);
      accept  = (state == S_CAPTURE) && in_valid && !start;
      xfer    = out_valid && out_ready;
      done    = (state == S_DRAIN) && xfer && (rd_ptr == CW'(N));
      case (state)
         S_IDLE:    state_n = start ? S_CAPTURE : S_IDLE;
         S_CAPTURE: state_n = (accept && wr_ptr == CW'(N-1)) ? S_FULL : S_CAPTURE;
         S_FULL:    state_n = start ? S_CAPTURE : (rd_en ? S_DRAIN : S_FULL);
         S_DRAIN:   state_n = done ? S_IDLE : S_DRAIN;
         default:   state_n = S_IDLE;
      endcase
      load = (state == S_FULL) && (state_n == S_DRAIN);
   end

   // buffer storage carries no reset; contents are only meaningful once captured
   always_ff @(posedge clk)
      if (accept) mem[wr_ptr[AW-1:0]] <= in_data;

   // capture side: write pointer and word count
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (restart) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (accept) begin
         wr_ptr <= wr_ptr + 1'b1;
         count  <= count + 1'b1;
      end else if (done) begin
         wr_ptr <= '0;
         count  <= '0;
      end

   // readout side: rd_ptr always points at the word to present after the current one
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rd_ptr    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (load) begin
         out_data  <= mem[0];
         out_valid <= 1'b1;
         rd_ptr    <= CW'(1);
      end else if (done) begin
         out_valid <= 1'b0;
         rd_ptr    <= '0;
      end else if ((state == S_DRAIN) && xfer) begin
         out_data  <= mem[rd_ptr[AW-1:0]];
         rd_ptr    <= rd_ptr + 1'b1;
      end

`ifdef RESULT_CAPTURE_NAN_CHECK_EN
   // sticky flag for accepted words with an all-ones exponent, cleared by a new run
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n)                                nan_flag <= 1'b0;
      else if (restart)                          nan_flag <= 1'b0;
      else if (accept && in_data[30:23] == 8'hFF) nan_flag <= 1'b1;
`else
   assign nan_flag = 1'b0;
`endif

endmodule

// File: tb/tb_result_capture_mem.sv
// tb_result_capture_mem: scoreboard bench for result_capture_mem with directed vectors.
module tb_result_capture_mem;
   localparam int N = 4;
   localparam int W = 32;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   start = 1'b0;
   logic                   in_valid = 1'b0;
   logic [W-1:0]           in_data = '0;
   logic                   in_ready;
   logic                   rd_en = 1'b0;
   logic                   out_valid;
   logic [W-1:0]           out_data;
   logic                   out_ready = 1'b0;
   logic                   full;
   logic [$clog2(N+1)-1:0] count;
   logic                   nan_flag;

   int tests = 0;
   int fails = 0;
   logic [W-1:0] exp_q[$];

`ifdef RESULT_CAPTURE_NAN_CHECK_EN
   localparam logic NAN_EXP = 1'b1;
`else
   localparam logic NAN_EXP = 1'b0;
`endif

   result_capture_mem #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .rd_en(rd_en), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .full(full), .count(count), .nan_flag(nan_flag)
   );

   always #5 clk = ~clk;

   function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // monitor: every transfer on the output port is checked against the scoreboard
   always @(negedge clk)
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got %h expected no transfer", out_data);
         end else chk("out_data", out_data, exp_q.pop_front());
      end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic capture(input logic [W-1:0] w[4]);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("count_after_start", 32'(count), 0);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = w[i];
         chk("in_ready_capture", 32'(in_ready), 1);
         tick();
      end
      in_valid = 1'b0;
      chk("full_after_capture", 32'(full), 1);
      chk("count_after_capture", 32'(count), N);
      chk("in_ready_in_full", 32'(in_ready), 0);
   endtask

   task automatic readout(input logic [W-1:0] w[4]);
      for (int i = 0; i < 4; i++) exp_q.push_back(w[i]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("out_valid_rise", 32'(out_valid), 1);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("out_valid_after_drain", 32'(out_valid), 0);
      chk("full_after_drain", 32'(full), 0);
      chk("count_after_drain", 32'(count), 0);
   endtask

   initial begin
      logic [W-1:0] v1[4]  = '{32'h3e4ccccd, 32'hbf800000, 32'hbf800000, 32'h3e4ccccd};
      logic [W-1:0] v2[4]  = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
      logic [W-1:0] vn[4]  = '{32'h3f800000, 32'h7fc00000, 32'h00000000, 32'h7f800000};
      logic         pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      #12;
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_nan", 32'(nan_flag), 0);
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 32'hdeadbeef;
      tick();
      in_valid = 1'b0;
      chk("idle_ignores_in", 32'(count), 0);
      chk("idle_in_ready", 32'(in_ready), 0);

      capture(v1);
      for (int i = 0; i < 4; i++) exp_q.push_back(v1[i]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      chk("bp_out_valid_rise", 32'(out_valid), 1);
      for (int i = 0; i < 6; i++) begin
         out_ready = pat[i];
         if (!pat[i]) begin
            chk("bp_hold_data", out_data, v1[1]);
            chk("bp_hold_valid", 32'(out_valid), 1);
         end
         tick();
      end
      out_ready = 1'b0;
      chk("bp_done_valid", 32'(out_valid), 0);
      chk("bp_done_full", 32'(full), 0);
      chk("bp_done_count", 32'(count), 0);
      chk("bp_q_empty", 32'(exp_q.size()), 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'haaaaaaaa;
      tick();
      in_data  = 32'hbbbbbbbb;
      tick();
      chk("restart_pre_count", 32'(count), 2);
      start   = 1'b1;
      in_data = 32'h40000000;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      chk("restart_count", 32'(count), 0);
      chk("restart_in_ready", 32'(in_ready), 1);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = v2[i];
         tick();
      end
      in_valid = 1'b0;
      chk("restart_full", 32'(full), 1);
      readout(v2);

      capture(v1);
      for (int i = 0; i < 4; i++) exp_q.push_back(v1[i]);
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_full", 32'(full), 0);
      chk("arst_count", 32'(count), 0);
      exp_q.delete();
      out_ready = 1'b0;
      #1;
      rst_n = 1'b1;
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
      out_ready = 1'b1;
      tick();
      chk("arst_rd_ignored_valid", 32'(out_valid), 0);
      chk("arst_rd_ignored_full", 32'(full), 0);
      out_ready = 1'b0;

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data  = vn[i];
         tick();
         if (i == 0) chk("nan_after_w1", 32'(nan_flag), 0);
         if (i == 1) chk("nan_after_w2", 32'(nan_flag), 32'(NAN_EXP));
      end
      in_valid = 1'b0;
      chk("nan_sticky", 32'(nan_flag), 32'(NAN_EXP));
      readout(vn);
      chk("nan_after_drain", 32'(nan_flag), 32'(NAN_EXP));
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("nan_cleared", 32'(nan_flag), 0);
      tick();
      chk("final_q_empty", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
